// File: rtl/vend_pkg.sv
// Shared vending definitions: coin encodings, dispenser FSM states and
// denomination values common to the change dispenser and credit/display logic.
package vend_pkg;

    localparam int unsigned AMT_W = 32;
    localparam int unsigned INV_W = 8;

    localparam int unsigned NICKEL_CENTS  = 5;
    localparam int unsigned DIME_CENTS    = 10;
    localparam int unsigned QUARTER_CENTS = 25;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_NICKEL  = 2'b01,
        COIN_DIME    = 2'b10,
        COIN_QUARTER = 2'b11
    } coin_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_FINISH   = 2'd3
    } disp_state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Request / coin-mechanism handshake bundle of the change dispenser.
// slave = dispenser side, master = host and coin mechanism side.
interface change_dispenser_if;

    logic                       start;
    logic [vend_pkg::AMT_W-1:0] amount;
    logic                       busy;
    logic                       coin_valid;
    logic [1:0]                 coin_sel;
    logic                       coin_ack;
    logic                       done;
    logic [vend_pkg::AMT_W-1:0] remainder;
    logic                       restock;
    logic                       short;

    modport slave (
        input  start, amount, coin_ack, restock,
        output busy, coin_valid, coin_sel, done, remainder, short
    );

    modport master (
        output start, amount, coin_ack, restock,
        input  busy, coin_valid, coin_sel, done, remainder, short
    );

endinterface

// File: rtl/coin_selector.sv
// Greedy coin choice: largest denomination that fits in work and is not empty.
module coin_selector
    import vend_pkg::*;
#(
    parameter int unsigned NICKEL  = NICKEL_CENTS,
    parameter int unsigned DIME    = DIME_CENTS,
    parameter int unsigned QUARTER = QUARTER_CENTS
) (
    input  logic [AMT_W-1:0] work,
    input  logic [2:0]       empty,    // {quarter, dime, nickel}
    output coin_sel_t        sel_c,
    output logic [AMT_W-1:0] value_c
);

    always_comb begin
        sel_c   = COIN_NONE;
        value_c = '0;
        if (work >= AMT_W'(QUARTER) && !empty[2]) begin
            sel_c   = COIN_QUARTER;
            value_c = AMT_W'(QUARTER);
        end else if (work >= AMT_W'(DIME) && !empty[1]) begin
            sel_c   = COIN_DIME;
            value_c = AMT_W'(DIME);
        end else if (work >= AMT_W'(NICKEL) && !empty[0]) begin
            sel_c   = COIN_NICKEL;
            value_c = AMT_W'(NICKEL);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an amount as quarters/dimes/nickels over a coin
// valid/ack handshake. Define COIN_INVENTORY_EN for finite per-coin inventory.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned NICKEL     = NICKEL_CENTS,
    parameter int unsigned DIME       = DIME_CENTS,
    parameter int unsigned QUARTER    = QUARTER_CENTS,
    parameter int unsigned MAX_AMOUNT = 9999
`ifdef COIN_INVENTORY_EN
    ,
    parameter int unsigned INV_INIT   = 20
`endif
) (
    input  logic               clock,
    input  logic               reset,
    change_dispenser_if.slave  bus
);

    disp_state_t      state, state_nx;
    logic [AMT_W-1:0] work, work_nx;
    logic [AMT_W-1:0] amount_clamped_c;
    logic [2:0]       inv_empty;
    coin_sel_t        pick_sel_c;
    logic [AMT_W-1:0] pick_value_c;

    logic             busy_q, busy_nx;
    logic             valid_q, valid_nx;
    coin_sel_t        sel_q, sel_nx;
    logic             done_q, done_nx;
    logic [AMT_W-1:0] rem_q, rem_nx;

    function automatic logic [AMT_W-1:0] coin_value(input coin_sel_t s);
        case (s)
            COIN_QUARTER: coin_value = AMT_W'(QUARTER);
            COIN_DIME:    coin_value = AMT_W'(DIME);
            COIN_NICKEL:  coin_value = AMT_W'(NICKEL);
            default:      coin_value = '0;
        endcase
    endfunction

    assign amount_clamped_c = (bus.amount > AMT_W'(MAX_AMOUNT)) ? AMT_W'(MAX_AMOUNT) : bus.amount;

    coin_selector #(
        .NICKEL  (NICKEL),
        .DIME    (DIME),
        .QUARTER (QUARTER)
    ) u_coin_selector (
        .work    (work),
        .empty   (inv_empty),
        .sel_c   (pick_sel_c),
        .value_c (pick_value_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            work    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            sel_q   <= COIN_NONE;
            done_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state   <= state_nx;
            work    <= work_nx;
            busy_q  <= busy_nx;
            valid_q <= valid_nx;
            sel_q   <= sel_nx;
            done_q  <= done_nx;
            rem_q   <= rem_nx;
        end
    end

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_nx = state;
        work_nx  = work;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    work_nx  = amount_clamped_c;
                    state_nx = ST_SELECT;
                end
            end
            ST_SELECT: begin
                state_nx = (pick_sel_c != COIN_NONE) ? ST_DISPENSE : ST_FINISH;
            end
            ST_DISPENSE: begin
                // sel_q was chosen with work >= its value, so no underflow
                if (bus.coin_ack) begin
                    work_nx  = work - coin_value(sel_q);
                    state_nx = ST_SELECT;
                end
            end
            ST_FINISH: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx  = (state_nx != ST_IDLE);
        valid_nx = (state_nx == ST_DISPENSE);
        sel_nx   = COIN_NONE;
        if (state_nx == ST_DISPENSE) begin
            sel_nx = (state == ST_SELECT) ? pick_sel_c : sel_q;
        end
        done_nx  = (state_nx == ST_FINISH);
        rem_nx   = done_nx ? work : rem_q;
    end

    assign bus.busy       = busy_q;
    assign bus.coin_valid = valid_q;
    assign bus.coin_sel   = sel_q;
    assign bus.done       = done_q;
    assign bus.remainder  = rem_q;

`ifdef COIN_INVENTORY_EN
    logic [INV_W-1:0] nickel_cnt, dime_cnt, quarter_cnt;
    logic             short_q;
    logic             short_nx_c;

    assign inv_empty  = {quarter_cnt == '0, dime_cnt == '0, nickel_cnt == '0};
    assign short_nx_c = (state_nx == ST_FINISH) && (work >= AMT_W'(NICKEL));

    // Restock wins over a decrement landing in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            nickel_cnt  <= INV_W'(INV_INIT);
            dime_cnt    <= INV_W'(INV_INIT);
            quarter_cnt <= INV_W'(INV_INIT);
            short_q     <= 1'b0;
        end else begin
            short_q <= short_nx_c;
            if (bus.restock) begin
                nickel_cnt  <= INV_W'(INV_INIT);
                dime_cnt    <= INV_W'(INV_INIT);
                quarter_cnt <= INV_W'(INV_INIT);
            end else if (state == ST_DISPENSE && bus.coin_ack) begin
                case (sel_q)
                    COIN_NICKEL:  nickel_cnt  <= nickel_cnt  - INV_W'(1);
                    COIN_DIME:    dime_cnt    <= dime_cnt    - INV_W'(1);
                    COIN_QUARTER: quarter_cnt <= quarter_cnt - INV_W'(1);
                    default:      ;
                endcase
            end
        end
    end

    assign bus.short = short_q;
`else
    assign inv_empty = 3'b000;
    assign bus.short = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized
// requests against a greedy change-making model (inventory-aware when enabled).
module tb_change_dispenser;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    change_dispenser_if bus ();

    change_dispenser dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

`ifdef COIN_INVENTORY_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: index 0 nickel, 1 dime, 2 quarter
    int          m_inv[3];
    int          coin_val[3] = '{5, 10, 25};
    logic [1:0]  exp_q[$];
    logic [1:0]  got_q[$];
    int          exp_rem;
    bit          exp_short;

    // Observations gathered by drive_request
    int          done_cyc, stab_err, space_err, width_err, hold_cyc;
    logic [31:0] obs_rem;
    logic        obs_short, obs_busy;

    task automatic model_restock();
        for (int i = 0; i < 3; i++) m_inv[i] = 20;
    endtask

    task automatic model_request(input logic [31:0] amt);
        int w;
        bit found;
        exp_q.delete();
        w = (amt > 32'd9999) ? 9999 : int'(amt);
        forever begin
            found = 1'b0;
            for (int d = 2; d >= 0; d--) begin
                if (!found && w >= coin_val[d] && (!INV_EN || m_inv[d] > 0)) begin
                    exp_q.push_back(2'(d + 1));
                    w -= coin_val[d];
                    if (INV_EN) m_inv[d]--;
                    found = 1'b1;
                end
            end
            if (!found) break;
        end
        exp_rem   = w;
        exp_short = INV_EN && (w >= 5);
    endtask

    function automatic bit seq_eq();
        if (got_q.size() != exp_q.size()) return 1'b0;
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Issue one request, act as coin mechanism, record what the DUT did.
    task automatic drive_request(input logic [31:0] amt, input int fixed_delay,
                                 input int max_delay, input bit poke_start, input int budget);
        int         cyc, wait_cnt, delay;
        bit         waiting, poked, ack_prev, ack_this;
        logic [1:0] cur_sel;
        got_q.delete();
        done_cyc = -1; stab_err = 0; space_err = 0; width_err = 0; hold_cyc = 0;
        obs_rem = 'x; obs_short = 1'bx; obs_busy = 1'bx;
        waiting = 0; poked = 0; ack_prev = 0; wait_cnt = 0; delay = 0; cur_sel = 2'b00;
        @(posedge clk); #1;
        bus.amount = amt;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (cyc < budget) begin
            bus.start    = 1'b0;
            bus.amount   = $urandom;
            bus.coin_ack = 1'b0;
            ack_this     = 1'b0;
            if (ack_prev && bus.coin_valid) space_err++;
            if (bus.done) begin
                done_cyc  = cyc;
                obs_rem   = bus.remainder;
                obs_short = bus.short;
                obs_busy  = bus.busy;
                break;
            end
            if (bus.coin_valid) begin
                if (!waiting) begin
                    waiting  = 1'b1;
                    cur_sel  = bus.coin_sel;
                    wait_cnt = 0;
                    delay    = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, max_delay));
                end else if (bus.coin_sel !== cur_sel) begin
                    stab_err++;
                end
                if (poke_start && !poked && wait_cnt == 1) begin
                    bus.start  = 1'b1;
                    bus.amount = 32'd95;
                    poked      = 1'b1;
                end
                if (wait_cnt == delay) begin
                    bus.coin_ack = 1'b1;
                    got_q.push_back(cur_sel);
                    hold_cyc = wait_cnt + 1;
                    waiting  = 1'b0;
                    ack_this = 1'b1;
                end
                wait_cnt++;
            end else begin
                bus.coin_ack = ($urandom_range(0, 3) == 0);
            end
            ack_prev = ack_this;
            @(posedge clk); #1;
            cyc++;
        end
        bus.start    = 1'b0;
        bus.coin_ack = 1'b0;
        if (done_cyc >= 0) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) width_err++;
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (bus.busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.coin_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.coin_valid); end
        n_cmp++; if (bus.coin_sel !== 2'b00)  begin n_bad++; $display("FAIL reset_sel: got %b want 00", bus.coin_sel); end
        n_cmp++; if (bus.done !== 1'b0)       begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.remainder !== 32'd0) begin n_bad++; $display("FAIL reset_rem: got %0d want 0", bus.remainder); end
        n_cmp++; if (bus.short !== 1'b0)      begin n_bad++; $display("FAIL reset_short: got %b want 0", bus.short); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_restock();
    endtask

    task automatic test_amount_40();
        model_request(32'd40);
        drive_request(32'd40, 0, 0, 1'b0, 200);
        n_cmp++; if (done_cyc < 0) begin n_bad++; $display("FAIL a40_done: no done within budget"); end
        n_cmp++; if (!seq_eq() || got_q.size() != 3 || got_q[0] !== 2'b11 || got_q[1] !== 2'b10 || got_q[2] !== 2'b01)
            begin n_bad++; $display("FAIL a40_coins: got %0d coins want Q,D,N", got_q.size()); end
        n_cmp++; if (obs_rem !== 32'd0) begin n_bad++; $display("FAIL a40_rem: got %0d want 0", obs_rem); end
        n_cmp++; if (space_err != 0 || width_err != 0 || stab_err != 0)
            begin n_bad++; $display("FAIL a40_proto: space %0d width %0d stab %0d want 0", space_err, width_err, stab_err); end
    endtask

    task automatic test_residue();
        model_request(32'd7);
        drive_request(32'd7, 0, 0, 1'b0, 200);
        n_cmp++; if (!seq_eq() || got_q.size() != 1 || got_q[0] !== 2'b01)
            begin n_bad++; $display("FAIL a7_coins: got %0d coins want one nickel", got_q.size()); end
        n_cmp++; if (obs_rem !== 32'd2) begin n_bad++; $display("FAIL a7_rem: got %0d want 2", obs_rem); end
        n_cmp++; if (obs_busy !== 1'b1) begin n_bad++; $display("FAIL a7_busy_finish: got %b want 1", obs_busy); end
    endtask

    task automatic test_zero();
        model_request(32'd0);
        drive_request(32'd0, 0, 0, 1'b0, 50);
        n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL a0_coins: got %0d want 0", got_q.size()); end
        n_cmp++; if (done_cyc != 2) begin n_bad++; $display("FAIL a0_latency: got %0d want 2", done_cyc); end
        n_cmp++; if (obs_rem !== 32'd0) begin n_bad++; $display("FAIL a0_rem: got %0d want 0", obs_rem); end
    endtask

    task automatic test_slow_ack();
        int bad_idle;
        model_request(32'd25);
        drive_request(32'd25, 4, 0, 1'b1, 200);
        n_cmp++; if (!seq_eq() || got_q.size() != 1 || got_q[0] !== 2'b11)
            begin n_bad++; $display("FAIL slow_coins: got %0d coins want one quarter", got_q.size()); end
        n_cmp++; if (hold_cyc != 5 || stab_err != 0)
            begin n_bad++; $display("FAIL slow_hold: got %0d cycles stab %0d want 5 stab 0", hold_cyc, stab_err); end
        n_cmp++; if (obs_rem !== 32'd0) begin n_bad++; $display("FAIL slow_rem: got %0d want 0", obs_rem); end
        bad_idle = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.busy || bus.coin_valid || bus.done) bad_idle++;
        end
        n_cmp++; if (bad_idle != 0) begin n_bad++; $display("FAIL slow_start_ignored: got %0d busy cycles want 0", bad_idle); end
    endtask

    task automatic test_reset_midway();
        int seen, bad_after;
        seen = 0;
        @(posedge clk); #1;
        bus.amount = 32'd50;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.coin_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL rst_mid_valid: got no coin_valid want one"); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.busy, bus.coin_valid, bus.coin_sel, bus.done, bus.short} !== 6'b0 || bus.remainder !== 32'd0)
            begin n_bad++; $display("FAIL rst_mid_outputs: got busy %b valid %b sel %b done %b rem %0d want all 0",
                                    bus.busy, bus.coin_valid, bus.coin_sel, bus.done, bus.remainder); end
        model_restock();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.coin_ack = 1'b1;
        @(posedge clk); #1;
        bus.coin_ack = 1'b0;
        bad_after = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.busy || bus.coin_valid || bus.coin_sel != 2'b00 || bus.done) bad_after++;
            @(posedge clk); #1;
        end
        n_cmp++; if (bad_after != 0) begin n_bad++; $display("FAIL rst_mid_stray_ack: got %0d active cycles want 0", bad_after); end
    endtask

    task automatic test_random();
        int amt;
        for (int n = 0; n < 30; n++) begin
            if (n % 8 == 0) begin
                @(posedge clk); #1; bus.restock = 1'b1;
                @(posedge clk); #1; bus.restock = 1'b0;
                if (INV_EN) model_restock();
            end
            amt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 260));
            model_request(32'(amt));
            drive_request(32'(amt), -1, 3, ($urandom_range(0, 1) == 1), 1000);
            n_cmp++; if (done_cyc < 0 || !seq_eq())
                begin n_bad++; $display("FAIL rand_coins amt=%0d: got %0d coins done@%0d want %0d coins", amt, got_q.size(), done_cyc, exp_q.size()); end
            n_cmp++; if (obs_rem !== 32'(exp_rem))
                begin n_bad++; $display("FAIL rand_rem amt=%0d: got %0d want %0d", amt, obs_rem, exp_rem); end
            n_cmp++; if (obs_short !== exp_short)
                begin n_bad++; $display("FAIL rand_short amt=%0d: got %b want %b", amt, obs_short, exp_short); end
            n_cmp++; if (space_err != 0 || width_err != 0 || stab_err != 0)
                begin n_bad++; $display("FAIL rand_proto amt=%0d: space %0d width %0d stab %0d want 0", amt, space_err, width_err, stab_err); end
        end
    endtask

    task automatic test_clamp();
        @(posedge clk); #1; bus.restock = 1'b1;
        @(posedge clk); #1; bus.restock = 1'b0;
        if (INV_EN) model_restock();
        model_request(32'hFFFF_FFF0);
        drive_request(32'hFFFF_FFF0, 0, 0, 1'b0, 5000);
        n_cmp++; if (done_cyc < 0 || !seq_eq())
            begin n_bad++; $display("FAIL clamp_coins: got %0d coins want %0d", got_q.size(), exp_q.size()); end
        n_cmp++; if (obs_rem !== 32'(exp_rem))
            begin n_bad++; $display("FAIL clamp_rem: got %0d want %0d", obs_rem, exp_rem); end
    endtask

`ifdef COIN_INVENTORY_EN
    task automatic inv_prepare(input int nickels_used);
        @(posedge clk); #1; bus.restock = 1'b1;
        @(posedge clk); #1; bus.restock = 1'b0;
        model_restock();
        for (int i = 0; i < 19; i++) begin model_request(32'd10); drive_request(32'd10, 0, 0, 1'b0, 100); end
        for (int i = 0; i < nickels_used; i++) begin model_request(32'd5); drive_request(32'd5, 0, 0, 1'b0, 100); end
        model_request(32'd475);
        drive_request(32'd475, 0, 0, 1'b0, 500);
    endtask

    task automatic test_inventory();
        inv_prepare(0);
        model_request(32'd60);
        drive_request(32'd60, 0, 0, 1'b0, 200);
        n_cmp++; if (!seq_eq() || got_q.size() != 5)
            begin n_bad++; $display("FAIL inv_full_coins: got %0d coins want Q,D,N,N,N", got_q.size()); end
        n_cmp++; if (obs_rem !== 32'd0 || obs_short !== 1'b0)
            begin n_bad++; $display("FAIL inv_full_done: got rem %0d short %b want 0 0", obs_rem, obs_short); end
        inv_prepare(20);
        model_request(32'd60);
        drive_request(32'd60, 0, 0, 1'b0, 200);
        n_cmp++; if (!seq_eq() || got_q.size() != 2)
            begin n_bad++; $display("FAIL inv_short_coins: got %0d coins want Q,D", got_q.size()); end
        n_cmp++; if (obs_rem !== 32'd25 || obs_short !== 1'b1)
            begin n_bad++; $display("FAIL inv_short_done: got rem %0d short %b want 25 1", obs_rem, obs_short); end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.amount   = '0;
        bus.coin_ack = 1'b0;
        bus.restock  = 1'b0;
        model_restock();
        test_reset();
        test_amount_40();
        test_residue();
        test_zero();
        test_slow_ack();
        test_reset_midway();
        test_random();
        test_clamp();
`ifdef COIN_INVENTORY_EN
        test_inventory();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter NICKEL, 5, nickel value in cents.
REQ-002 Parameter DIME, 10, dime value in cents.
REQ-003 Parameter QUARTER, 25, quarter value in cents.
REQ-004 Parameter MAX_AMOUNT, 9999, largest amount accepted; larger requests SHALL be clamped to it.
REQ-005 Parameter INV_INIT, 20, per-denomination coin count loaded at reset and on restock (inventory build only).
REQ-006 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle request to return change; sampled only in IDLE.
REQ-009 amount  input  32  change to return, in cents, unsigned; sampled with start.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 coin_valid  output  1  coin-ejection request to the coin mechanism.
REQ-012 coin_sel  output  2  denomination: 00 none, 01 nickel, 10 dime, 11 quarter.
REQ-013 coin_ack  input  1  one-cycle acknowledge from the coin mechanism that the coin was ejected.
REQ-014 done  output  1  one-cycle pulse when the request is complete.
REQ-015 remainder  output  32  amount left undispensed; valid from the done cycle until the next start.
REQ-016 restock  input  1  reload all inventory counters to INV_INIT (inventory build only).
REQ-017 short  output  1  high with done when remainder >= NICKEL because of empty inventory (inventory build only).

Function
REQ-018 The FSM SHALL have states IDLE, SELECT, DISPENSE and FINISH.
REQ-019 IDLE: start=1 SHALL latch min(amount, MAX_AMOUNT) into a 32-bit working register and enter SELECT on the next cycle.
REQ-020 SELECT SHALL pick greedily: quarter if work>=QUARTER, else dime if work>=DIME, else nickel if work>=NICKEL, and then enter DISPENSE; if no coin is possible it SHALL enter FINISH.
REQ-021 DISPENSE SHALL drive coin_valid=1, and coin_sel SHALL stay stable until coin_ack=1 is sampled.
REQ-022 On coin_ack in DISPENSE, the FSM SHALL subtract the coin value from work, deassert coin_valid the next cycle and return to SELECT.
REQ-023 Coin-to-coin spacing SHALL be at least 2 cycles: an ack cycle, then a SELECT cycle.
REQ-024 FINISH SHALL pulse done for exactly one cycle, load remainder with work and return to IDLE.
REQ-025 coin_ack outside DISPENSE SHALL be ignored, and start outside IDLE SHALL be ignored.
REQ-026 amount=0 SHALL produce no coin and done two cycles after start.
REQ-027 An amount that is not a multiple of 5 SHALL leave the residue (1-4) in remainder.
REQ-028 The subtraction SHALL never underflow, because the selection guarantees work >= coin value.

Reset
REQ-029 reset low SHALL immediately force IDLE, with work=0, remainder=0, busy=0, coin_valid=0, coin_sel=00, done=0, short=0 and inventories=INV_INIT, including in the middle of a dispense.
REQ-030 A coin_ack arriving after reset has aborted a dispense SHALL be ignored.

Configuration
REQ-031 With macro COIN_INVENTORY_EN defined, the block SHALL keep three 8-bit coin counters, decrement the dispensed denomination on coin_ack, skip empty denominations in SELECT (next smaller denomination chosen), assert short in FINISH when work>=NICKEL, and implement restock (which takes priority over a same-cycle decrement).
REQ-032 Without COIN_INVENTORY_EN, the restock input SHALL be ignored, short SHALL be tied to 0, no counters SHALL exist, and the supply is unlimited.

Structure
REQ-033 A shared package vend_pkg SHALL hold the coin_sel encodings, the FSM state typedef and the denomination constants shared with the credit/display block.
REQ-034 One sub-module, coin_selector, is natural and SHALL be used: combinational greedy choice from work plus the inventory-empty flags, returning coin_sel and coin value.

Verification
REQ-035 amount=40, ack 1 cycle after each valid -> coin_sel 11, 10, 01 in sequence; done with remainder=0.
REQ-036 amount=7 -> a single nickel; done with remainder=2.
REQ-037 amount=0 -> no coin_valid; done exactly 2 cycles after start; remainder=0.
REQ-038 amount=25, ack delayed 5 cycles -> coin_valid/coin_sel=11 held stable for 5 cycles; a start during busy is ignored.
REQ-039 amount=50, reset asserted during the first DISPENSE, then a stray coin_ack -> all outputs at reset values; no coin dispensed; state stays IDLE.
REQ-040 COIN_INVENTORY_EN, quarters=1, dimes=1, amount=60 -> Q, D, N, N, N; done with remainder=0 and short=0. With nickels=0 instead -> Q, D; done with remainder=25 and short=1.
